// File: rtl/ahbl_splitter_burst.sv
// AHB-Lite 1:N address-decoding splitter with a two-cycle decode-error responder and a
// saturating error counter. Define AHBL_SPLITTER_BURST_LOCK_EN to pin SEQ/BUSY beats to the NONSEQ decode.
module ahbl_splitter_burst #(
  parameter int                          N_PORTS   = 2,
  parameter int                          W_ADDR    = 32,
  parameter int                          W_DATA    = 32,
  parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MAP  = 64'h20000000_00000000,
  parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MASK = 64'hf0000000_f0000000,
  parameter logic [N_PORTS-1:0]          CONN_MASK = '1,
  parameter int                          W_ERRCNT  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          src_hready,
  output logic                          src_hready_resp,
  output logic                          src_hresp,
  input  logic [W_ADDR-1:0]             src_haddr,
  input  logic                          src_hwrite,
  input  logic [1:0]                    src_htrans,
  input  logic [2:0]                    src_hsize,
  input  logic [2:0]                    src_hburst,
  input  logic [3:0]                    src_hprot,
  input  logic                          src_hmastlock,
  input  logic [W_DATA-1:0]             src_hwdata,
  output logic [W_DATA-1:0]             src_hrdata,
  output logic [N_PORTS-1:0]            dst_hready,
  input  logic [N_PORTS-1:0]            dst_hready_resp,
  input  logic [N_PORTS-1:0]            dst_hresp,
  output logic [N_PORTS*W_ADDR-1:0]     dst_haddr,
  output logic [N_PORTS-1:0]            dst_hwrite,
  output logic [2*N_PORTS-1:0]          dst_htrans,
  output logic [3*N_PORTS-1:0]          dst_hsize,
  output logic [3*N_PORTS-1:0]          dst_hburst,
  output logic [4*N_PORTS-1:0]          dst_hprot,
  output logic [N_PORTS-1:0]            dst_hmastlock,
  output logic [N_PORTS*W_DATA-1:0]     dst_hwdata,
  input  logic [N_PORTS*W_DATA-1:0]     dst_hrdata,
  output logic [W_ERRCNT-1:0]           err_count,
  input  logic                          err_clr,
  output logic [1:0]                    dbg_state_o
);

  // Handshake: an address-phase beat (src_htrans != IDLE) is accepted on a rising edge with
  // src_hready=1; its data phase ends on the first edge where src_hready_resp=1.

  typedef enum logic [1:0] {ST_OK = 2'd0, ST_ERR1 = 2'd1, ST_ERR2 = 2'd2} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  state_t               state_q, state_d;
  logic [N_PORTS-1:0]   dsel_q, dsel_d;
  logic [W_ERRCNT-1:0]  err_cnt_q, err_cnt_d;
  logic [N_PORTS-1:0]   dec_sel, eff_sel;
  logic                 dec_err, eff_err, err_inc;

  // Unconnected ports are masked out here, so "no hit" covers both unmapped and unconnected.
  always_comb begin
    dec_sel = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (((src_haddr ^ ADDR_MAP[i*W_ADDR +: W_ADDR]) & ADDR_MASK[i*W_ADDR +: W_ADDR]) == '0)
        dec_sel[i] = CONN_MASK[i];
    end
    if (src_htrans == HTRANS_IDLE) dec_sel = '0;
    dec_err = (src_htrans != HTRANS_IDLE) && (dec_sel == '0);
  end

`ifdef AHBL_SPLITTER_BURST_LOCK_EN
  logic [N_PORTS-1:0] lock_sel_q, lock_sel_d;
  logic               lock_err_q, lock_err_d;
  logic               in_burst;

  always_comb begin
    lock_sel_d = lock_sel_q;
    lock_err_d = lock_err_q;
    if (src_hready) begin
      if (src_htrans == HTRANS_NONSEQ) begin
        lock_sel_d = dec_sel;
        lock_err_d = dec_err;
      end else if (src_htrans == HTRANS_IDLE) begin
        lock_sel_d = '0;
        lock_err_d = 1'b0;
      end
    end
    in_burst = (src_htrans == HTRANS_SEQ) || (src_htrans == HTRANS_BUSY);
    eff_sel  = in_burst ? lock_sel_q : dec_sel;
    eff_err  = in_burst ? lock_err_q : dec_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_sel_q <= '0;
      lock_err_q <= 1'b0;
    end else begin
      lock_sel_q <= lock_sel_d;
      lock_err_q <= lock_err_d;
    end
  end
`else
  always_comb begin
    eff_sel = dec_sel;
    eff_err = dec_err;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OK:   if (src_hready && eff_err) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = (src_hready && eff_err) ? ST_ERR1 : ST_OK;
      default: state_d = ST_OK;
    endcase
  end

  always_comb begin
    dsel_d  = src_hready ? eff_sel : dsel_q;
    err_inc = (state_d == ST_ERR1) && (state_q != ST_ERR1);
    err_cnt_d = err_cnt_q;
    if (err_clr)
      err_cnt_d = W_ERRCNT'(err_inc);
    else if (err_inc && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OK;
      dsel_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dsel_q    <= dsel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Response path is driven only by registered data-phase state and slave inputs.
  always_comb begin
    src_hready_resp = 1'b1;
    src_hresp       = 1'b0;
    src_hrdata      = '0;
    case (state_q)
      ST_ERR1: begin
        src_hready_resp = 1'b0;
        src_hresp       = 1'b1;
      end
      ST_ERR2: begin
        src_hready_resp = 1'b1;
        src_hresp       = 1'b1;
      end
      default: begin
        if (dsel_q != '0) begin
          src_hready_resp = |(dsel_q & dst_hready_resp);
          src_hresp       = |(dsel_q & dst_hresp);
          for (int i = 0; i < N_PORTS; i++)
            src_hrdata = src_hrdata | (dst_hrdata[i*W_DATA +: W_DATA] & {W_DATA{dsel_q[i]}});
        end
      end
    endcase
  end

  always_comb begin
    dst_htrans = '0;
    for (int i = 0; i < N_PORTS; i++)
      dst_htrans[2*i +: 2] = eff_sel[i] ? src_htrans : HTRANS_IDLE;
  end

  assign dst_hready    = {N_PORTS{src_hready}};
  assign dst_haddr     = {N_PORTS{src_haddr}};
  assign dst_hwrite    = {N_PORTS{src_hwrite}};
  assign dst_hsize     = {N_PORTS{src_hsize}};
  assign dst_hburst    = {N_PORTS{src_hburst}};
  assign dst_hprot     = {N_PORTS{src_hprot}};
  assign dst_hmastlock = {N_PORTS{src_hmastlock}};
  assign dst_hwdata    = {N_PORTS{src_hwdata}};
  assign err_count     = err_cnt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ahbl_splitter_burst.sv
// Directed bench for ahbl_splitter_burst: decode table plus stall, error, saturation, burst and reset sequences.
// Map: port0 0x0xxx_xxxx, port1 0x2xxx_xxxx, port2 0x1xxx_xxxx, port3 0x3xxx_xxxx (unconnected).
module tb_ahbl_splitter_burst;

  localparam int NP = 4;
  localparam logic [NP*32-1:0] MAP  = {32'h3000_0000, 32'h1000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [NP*32-1:0] MASK = {4{32'hF000_0000}};
  localparam logic [NP-1:0]    CONN = 4'b0111;

  localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic              src_hready, src_hready_resp, src_hresp;
  logic [31:0]       src_haddr;
  logic              src_hwrite, src_hmastlock;
  logic [1:0]        src_htrans;
  logic [2:0]        src_hsize, src_hburst;
  logic [3:0]        src_hprot;
  logic [31:0]       src_hwdata, src_hrdata;
  logic [NP-1:0]     dst_hready, dst_hready_resp, dst_hresp, dst_hwrite, dst_hmastlock;
  logic [NP*32-1:0]  dst_haddr, dst_hwdata, dst_hrdata;
  logic [2*NP-1:0]   dst_htrans;
  logic [3*NP-1:0]   dst_hsize, dst_hburst;
  logic [4*NP-1:0]   dst_hprot;
  logic [7:0]        err_count;
  logic              err_clr;
  logic [1:0]        dbg_state;
  logic [NP-1:0][31:0] slv_rdata;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  // The master follows the bus HREADY returned by the splitter.
  assign src_hready = src_hready_resp;
  assign dst_hrdata = slv_rdata;

  ahbl_splitter_burst #(
    .N_PORTS(NP), .W_ADDR(32), .W_DATA(32), .ADDR_MAP(MAP), .ADDR_MASK(MASK),
    .CONN_MASK(CONN), .W_ERRCNT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
    .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
    .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
    .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
    .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
    .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
    .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
    .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata),
    .err_count(err_count), .err_clr(err_clr), .dbg_state_o(dbg_state)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [7:0]  exp_htrans;
    logic        exp_err;
    int          exp_port;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] slave_word(input int p);
    return 32'hD000_0000 + 32'(p);
  endfunction

  function automatic logic [7:0] htrans_for(input int p, input logic [1:0] t);
    logic [7:0] v;
    v = '0;
    v[2*p +: 2] = t;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_1000, T_NONSEQ, 8'h02, 1'b0, 0};
    vecs[1] = '{32'h2000_0010, T_NONSEQ, 8'h08, 1'b0, 1};
    vecs[2] = '{32'h1FFF_FFFC, T_NONSEQ, 8'h20, 1'b0, 2};
    vecs[3] = '{32'h3000_0000, T_NONSEQ, 8'h00, 1'b1, -1};
    vecs[4] = '{32'h4000_0000, T_NONSEQ, 8'h00, 1'b1, -1};
    vecs[5] = '{32'h4000_0000, T_IDLE,   8'h00, 1'b0, -1};
    vecs[6] = '{32'h2000_0000, T_IDLE,   8'h00, 1'b0, -1};
    vecs[7] = '{32'hF000_0000, T_NONSEQ, 8'h00, 1'b1, -1};
    vecs[8] = '{32'h0FFF_FFFF, T_NONSEQ, 8'h02, 1'b0, 0};

    // clock/reset and default bus values
    rst = 1'b1; err_clr = 1'b0;
    src_haddr = '0; src_htrans = T_IDLE; src_hwrite = 1'b0; src_hsize = 3'b010;
    src_hburst = 3'b000; src_hprot = 4'h3; src_hmastlock = 1'b0; src_hwdata = 32'h1234_5678;
    dst_hready_resp = '1; dst_hresp = '0;
    for (int i = 0; i < NP; i++) slv_rdata[i] = slave_word(i);
    #3;
    chk("rst_ready", src_hready_resp, 1'b1);
    chk("rst_hresp", src_hresp, 1'b0);
    chk("rst_hrdata", src_hrdata, 32'h0);
    chk("rst_errcnt", err_count, 8'h0);
    chk("rst_state", dbg_state, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // decode table
    for (int k = 0; k < 9; k++) begin
      src_haddr = vecs[k].addr; src_htrans = vecs[k].trans;
      #1;
      chk("tbl_htrans", dst_htrans, vecs[k].exp_htrans);
      chk("tbl_bcast", {dst_haddr[95:64], dst_hready}, {vecs[k].addr, 4'hF});
      tick();
      src_htrans = T_IDLE;
      #1;
      if (vecs[k].exp_err) begin
        exp_cnt++;
        chk("tbl_err1", {src_hready_resp, src_hresp}, 2'b01);
        chk("tbl_cnt", err_count, 64'(exp_cnt));
        tick();
        chk("tbl_err2", {src_hready_resp, src_hresp, src_hrdata}, {2'b11, 32'h0});
        tick();
        chk("tbl_ok", dbg_state, 2'd0);
      end else begin
        chk("tbl_resp", {src_hready_resp, src_hresp}, 2'b10);
        chk("tbl_rdata", src_hrdata, (vecs[k].exp_port >= 0) ? slave_word(vecs[k].exp_port) : 32'h0);
        chk("tbl_cnt", err_count, 64'(exp_cnt));
      end
    end
    tick();

    // read to port 1 with two wait states
    src_haddr = 32'h2000_0010; src_htrans = T_NONSEQ;
    #1 chk("stall_htrans", dst_htrans, 8'h08);
    tick();
    src_htrans = T_IDLE; dst_hready_resp[1] = 1'b0;
    #1 chk("stall_w1", src_hready_resp, 1'b0);
    tick();
    chk("stall_w2", src_hready_resp, 1'b0);
    dst_hready_resp[1] = 1'b1; slv_rdata[1] = 32'hCAFE_F00D;
    #1 chk("stall_done", {src_hready_resp, src_hresp, src_hrdata}, {2'b10, 32'hCAFE_F00D});
    tick();
    slv_rdata[1] = slave_word(1);

    // beat accepted during the second error cycle is decoded normally
    src_haddr = 32'h4000_0000; src_htrans = T_NONSEQ;
    tick();
    exp_cnt++;
    src_haddr = 32'h0000_0040;
    #1 chk("e2acc_err1", dbg_state, 2'd1);
    tick();
    chk("e2acc_err2", {src_hready_resp, src_hresp}, 2'b11);
    chk("e2acc_htrans", dst_htrans, 8'h02);
    tick();
    src_htrans = T_IDLE;
    #1 chk("e2acc_data", {src_hready_resp, src_hresp, src_hrdata}, {2'b10, slave_word(0)});
    chk("e2acc_cnt", err_count, 64'(exp_cnt));
    tick();

    // counter saturation and clear-with-increment
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1 chk("sat_clr", err_count, 8'h0);
    src_haddr = 32'h4000_0000; src_htrans = T_NONSEQ;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k < 3 || k > 252) chk("sat_cnt", err_count, 64'((k > 255) ? 255 : k));
      tick();
    end
    chk("sat_state", dbg_state, 2'd2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; src_htrans = T_IDLE;
    #1 chk("clr_inc_cnt", err_count, 8'h1);
    chk("clr_inc_state", dbg_state, 2'd1);
    tick();
    tick();
    chk("clr_inc_ok", dbg_state, 2'd0);

    // INCR4 crossing the port0/port2 boundary
    begin
      logic [31:0] baddr[4];
      logic [1:0]  btr[4];
      int          bport[4];
      baddr = '{32'h0FFF_FFF8, 32'h0FFF_FFFC, 32'h1000_0000, 32'h1000_0004};
      btr   = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ};
`ifdef AHBL_SPLITTER_BURST_LOCK_EN
      bport = '{0, 0, 0, 0};
`else
      bport = '{0, 0, 2, 2};
`endif
      src_hburst = 3'b011;
      for (int k = 0; k < 4; k++) begin
        src_haddr = baddr[k]; src_htrans = btr[k];
        #1 chk("burst_htrans", dst_htrans, htrans_for(bport[k], btr[k]));
        if (k > 0) chk("burst_rdata", src_hrdata, slave_word(bport[k-1]));
        tick();
      end
      src_htrans = T_IDLE; src_hburst = 3'b000;
      #1 chk("burst_last", src_hrdata, slave_word(bport[3]));
      tick();
    end

    // reset during a port-0 wait state
    src_haddr = 32'h0000_0000; src_htrans = T_NONSEQ;
    tick();
    src_htrans = T_IDLE; dst_hready_resp[0] = 1'b0;
    #1 chk("rstw_wait", src_hready_resp, 1'b0);
    rst = 1'b1;
    #1 chk("rstw_resp", {src_hready_resp, src_hresp, src_hrdata}, {2'b10, 32'h0});
    chk("rstw_cnt", err_count, 8'h0);
    chk("rstw_state", dbg_state, 2'd0);
    src_haddr = 32'h2000_0000; src_htrans = T_NONSEQ;
    #1 chk("rstw_decode", dst_htrans, 8'h08);
    src_htrans = T_IDLE; dst_hready_resp[0] = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rstw_after", {src_hready_resp, dbg_state}, {1'b1, 2'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
